// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling; completed bytes are held in a single register,
// or in a FIFO_DEPTH-entry FIFO when UART_RX_FIFO_EN is defined.
module uart_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    if (CLKS_PER_BIT < 4 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_rx: CLKS_PER_BIT must be >= 4 and FIFO_DEPTH a power of two >= 2");
    end

    // Reset asserts immediately but releases two clk edges after rst_n rises.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    logic [1:0]    r_sync;
    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_index;
    logic [7:0]    r_shift;
    logic          r_frame_err;
    logic          w_line;
    logic          w_expire;
    logic          w_stop_smp;
    logic          w_push;

    assign w_line     = r_sync[1];
    assign w_expire   = (r_timer == '0);
    assign w_stop_smp = (r_state == S_STOP) && w_expire;
    assign w_push     = w_stop_smp && w_line;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync      <= 2'b11;
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_index     <= 3'd0;
            r_shift     <= 8'h00;
            r_frame_err <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], uart_rx_pin};
            r_frame_err <= w_stop_smp && !w_line;
            case (r_state)
                S_IDLE: begin
                    if (!w_line) begin
                        r_state <= S_START;
                        r_timer <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (!w_expire) begin
                        r_timer <= r_timer - 1'b1;
                    end else if (!w_line) begin
                        r_state <= S_DATA;
                        r_timer <= FULL_LOAD;
                        r_index <= 3'd0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (!w_expire) begin
                        r_timer <= r_timer - 1'b1;
                    end else begin
                        r_shift[r_index] <= w_line;
                        r_timer          <= FULL_LOAD;
                        r_index          <= r_index + 3'd1;
                        if (r_index == 3'd7) r_state <= S_STOP;
                    end
                end
                default: begin
                    // Back to IDLE on the sample itself so a start bit right after stop is caught.
                    if (!w_expire) r_timer <= r_timer - 1'b1;
                    else           r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign frame_err = r_frame_err;

    logic r_overrun;
    assign overrun = r_overrun;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;

    assign w_full = (r_count == (AW + 1)'(FIFO_DEPTH));
    assign w_pop  = (r_count != '0) && rx_ready;
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_push && !w_wr;
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
        end
    end

    assign rx_data  = r_mem[r_rd_ptr];
    assign rx_valid = (r_count != '0);
`else
    logic [7:0] r_data;
    logic       r_valid;
    logic       w_pop;

    assign w_pop = r_valid && rx_ready;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_push && r_valid && !w_pop;
            if (w_push && (!r_valid || w_pop)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data  = r_data;
    assign rx_valid = r_valid;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16; works with or without UART_RX_FIFO_EN.
module tb_uart_rx;
    localparam int CPB = 16;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx_pin = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vld_cyc = 0;
    logic [7:0] rxq[$];

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx_pin(uart_rx_pin),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun)
    );

    always @(negedge clk) begin
        if (rx_valid && rx_ready) rxq.push_back(rx_data);
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
        if (rx_valid)  vld_cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Starts just after a clk edge; the stop sample lands on the 155th edge from here.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx_pin = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx_pin = b[i];
            tick(CPB);
        end
        uart_rx_pin = stop;
        tick(CPB);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %0b exp 0", rx_valid); end
        checks++; if (rx_data !== 8'h00)  begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %0b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_ovr got %0b exp 0", overrun); end
        tick(3);
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic test_single_byte();
        int v0, f0, o0;
        rxq.delete();
        v0 = vld_cyc; f0 = fe_cnt; o0 = ov_cnt;
        rx_ready = 1'b1;
        fork
            send_byte(8'h41, 1'b1);
            begin
                tick(154);
                checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_early got %0b exp 0", rx_valid); end
                tick(1);
                checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h41) begin
                    errors++; $display("FAIL single_first got %0b/%h exp 1/41", rx_valid, rx_data); end
            end
        join
        tick(8);
        checks++; if (vld_cyc - v0 != 1) begin errors++; $display("FAIL single_vld_cycles got %0d exp 1", vld_cyc - v0); end
        checks++; if (rxq.size() != 1 || rxq[0] !== 8'h41) begin
            errors++; $display("FAIL single_data got n=%0d exp one 41", rxq.size()); end
        checks++; if (fe_cnt != f0 || ov_cnt != o0) begin
            errors++; $display("FAIL single_err got fe=%0d ov=%0d exp 0 0", fe_cnt - f0, ov_cnt - o0); end
    endtask

    task automatic test_glitch();
        int v0, f0, o0;
        rxq.delete();
        v0 = vld_cyc; f0 = fe_cnt; o0 = ov_cnt;
        uart_rx_pin = 1'b0;
        tick(5);
        uart_rx_pin = 1'b1;
        tick(40);
        checks++; if (vld_cyc != v0) begin errors++; $display("FAIL glitch_valid got %0d exp 0", vld_cyc - v0); end
        checks++; if (fe_cnt != f0)  begin errors++; $display("FAIL glitch_ferr got %0d exp 0", fe_cnt - f0); end
        checks++; if (ov_cnt != o0)  begin errors++; $display("FAIL glitch_ovr got %0d exp 0", ov_cnt - o0); end
        send_byte(8'h96, 1'b1);
        tick(16);
        checks++; if (rxq.size() != 1 || rxq[0] !== 8'h96) begin
            errors++; $display("FAIL glitch_next got n=%0d exp one 96", rxq.size()); end
    endtask

    task automatic test_frame_err();
        int v0, f0;
        rxq.delete();
        v0 = vld_cyc; f0 = fe_cnt;
        send_byte(8'hA5, 1'b0);
        uart_rx_pin = 1'b1;
        tick(32);
        checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL ferr_pulse got %0d exp 1", fe_cnt - f0); end
        checks++; if (vld_cyc != v0)    begin errors++; $display("FAIL ferr_valid got %0d exp 0", vld_cyc - v0); end
        send_byte(8'h3C, 1'b1);
        tick(16);
        checks++; if (rxq.size() != 1 || rxq[0] !== 8'h3C) begin
            errors++; $display("FAIL ferr_next got n=%0d exp one 3C", rxq.size()); end
        checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL ferr_extra got %0d exp 1", fe_cnt - f0); end
    endtask

    task automatic test_back_to_back();
        int o0;
        rxq.delete();
        rx_ready = 1'b0;
        o0 = ov_cnt;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        tick(8);
        checks++; if (ov_cnt - o0 != 5 - CAP) begin
            errors++; $display("FAIL bp_overrun got %0d exp %0d", ov_cnt - o0, 5 - CAP); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h01) begin
            errors++; $display("FAIL bp_head got %0b/%h exp 1/01", rx_valid, rx_data); end
        rx_ready = 1'b1;
        tick(8);
        rx_ready = 1'b0;
        checks++; if (rxq.size() != CAP) begin errors++; $display("FAIL bp_count got %0d exp %0d", rxq.size(), CAP); end
        for (int i = 0; i < rxq.size(); i++) begin
            checks++; if (rxq[i] !== 8'(i + 1)) begin
                errors++; $display("FAIL bp_order[%0d] got %h exp %h", i, rxq[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_simultaneous();
        int o0;
        logic [7:0] exp_head;
        rxq.delete();
        rx_ready = 1'b0;
        for (int i = 0; i < CAP; i++) send_byte(8'(8'hA0 + i), 1'b1);
        tick(4);
        o0 = ov_cnt;
        fork
            send_byte(8'h5A, 1'b1);
            begin
                tick(154);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
        join
        tick(4);
        exp_head = (CAP == 1) ? 8'h5A : 8'hA1;
        checks++; if (ov_cnt != o0) begin errors++; $display("FAIL simul_overrun got %0d exp 0", ov_cnt - o0); end
        checks++; if (rxq.size() != 1 || rxq[0] !== 8'hA0) begin
            errors++; $display("FAIL simul_popped got n=%0d exp one A0", rxq.size()); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== exp_head) begin
            errors++; $display("FAIL simul_head got %0b/%h exp 1/%h", rx_valid, rx_data, exp_head); end
        rx_ready = 1'b1;
        tick(8);
        rx_ready = 1'b0;
        checks++; if (rxq.size() != CAP + 1 || rxq[rxq.size() - 1] !== 8'h5A) begin
            errors++; $display("FAIL simul_drain got n=%0d exp %0d ending 5A", rxq.size(), CAP + 1); end
    endtask

    task automatic test_reset_midframe();
        int f0, o0;
        rx_ready = 1'b0;
        send_byte(8'h77, 1'b1);
        tick(4);
        uart_rx_pin = 1'b0;
        tick(CPB);
        uart_rx_pin = 1'b1;
        tick(4 * CPB + 8);
        rst_n = 1'b0;
        #1;
        checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            errors++; $display("FAIL rst_async got %0b/%h exp 0/00", rx_valid, rx_data); end
        rxq.delete();
        rx_ready = 1'b1;
        f0 = fe_cnt; o0 = ov_cnt;
        tick(3);
        rst_n = 1'b1;
        tick(3 * CPB);
        send_byte(8'h12, 1'b1);
        tick(16);
        checks++; if (rxq.size() != 1 || rxq[0] !== 8'h12) begin
            errors++; $display("FAIL rst_mid_data got n=%0d exp one 12", rxq.size()); end
        checks++; if (fe_cnt != f0 || ov_cnt != o0) begin
            errors++; $display("FAIL rst_mid_err got fe=%0d ov=%0d exp 0 0", fe_cnt - f0, ov_cnt - o0); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_simultaneous();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "watchdog");
    end
endmodule
